// File: rtl/ram_io_responder.sv
// Byte-serial memory responder: RAM plus an I/O window with a TX FIFO, status and halt flag.
// Optional RX holding register enabled by defining IO_RX_EN.
module ram_io_responder #(
    parameter int ADDR_WIDTH = 17,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_rdy,
    input  logic [31:0] i_mem_a,
    input  logic [7:0]  i_mem_dout,
    input  logic        i_mem_wr,
    output logic [7:0]  o_mem_din,
    output logic        o_io_buffer_full,
    output logic        o_tx_valid,
    output logic [7:0]  o_tx_data,
    input  logic        i_tx_ready,
    output logic        o_sim_done
`ifdef IO_RX_EN
    ,
    input  logic        i_rx_valid,
    input  logic [7:0]  i_rx_data
`endif
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    logic [7:0]            r_ram [0:(1<<ADDR_WIDTH)-1];
    logic [7:0]            r_fifo [0:FIFO_DEPTH-1];
    logic [7:0]            r_ram_q;
    logic [7:0]            r_io_q;
    logic                  r_src_ram;
    logic [PW-1:0]         r_wr_ptr;
    logic [PW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_count;
    logic                  r_overflow;
    logic                  r_sim_done;
    logic                  r_io_buffer_full;

    logic                  w_is_io;
    logic [ADDR_WIDTH-1:0] w_ram_addr;
    logic                  w_ram_wr;
    logic                  w_ram_rd;
    logic                  w_io_sel0;
    logic                  w_io_sel4;
    logic                  w_push_req;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_tx_full;
    logic [CW-1:0]         w_count_next;
    logic                  w_rx_avail;
    logic [7:0]            w_rx_byte;
    logic                  w_rx_pop;
    logic                  w_rx_overflow;
    logic [7:0]            w_status;
    logic [7:0]            w_io_rd_data;
    logic                  w_unused_addr;

    assign w_unused_addr = ^i_mem_a[31:18];

    assign w_is_io    = (i_mem_a[17:16] == 2'b11);
    assign w_ram_addr = i_mem_a[ADDR_WIDTH-1:0];
    assign w_ram_wr   = i_rdy && i_mem_wr && !w_is_io;
    assign w_ram_rd   = i_rdy && !i_mem_wr && !w_is_io;
    assign w_io_sel0  = i_rdy && w_is_io && (i_mem_a[2:0] == 3'd0);
    assign w_io_sel4  = i_rdy && w_is_io && (i_mem_a[2:0] == 3'd4);

    assign w_tx_full    = (r_count == CW'(FIFO_DEPTH));
    assign o_tx_valid   = (r_count != '0);
    assign o_tx_data    = o_tx_valid ? r_fifo[r_rd_ptr] : 8'h00;
    assign w_pop        = o_tx_valid && i_tx_ready;
    assign w_push_req   = w_io_sel0 && i_mem_wr;
    // A pop in the same cycle frees the slot, so a push to a full FIFO still lands.
    assign w_push       = w_push_req && (!w_tx_full || w_pop);
    assign w_count_next = r_count + CW'(w_push) - CW'(w_pop);
    assign w_rx_pop     = w_io_sel0 && !i_mem_wr && w_rx_avail;

`ifdef IO_RX_EN
    logic       r_rx_avail;
    logic [7:0] r_rx_data;

    assign w_rx_avail    = r_rx_avail;
    assign w_rx_byte     = r_rx_data;
    assign w_rx_overflow = i_rx_valid && r_rx_avail && !w_rx_pop;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rx_avail <= 1'b0;
            r_rx_data  <= 8'h00;
        end else if (i_rx_valid && (!r_rx_avail || w_rx_pop)) begin
            r_rx_avail <= 1'b1;
            r_rx_data  <= i_rx_data;
        end else if (w_rx_pop) begin
            r_rx_avail <= 1'b0;
        end
    end
`else
    assign w_rx_avail    = 1'b0;
    assign w_rx_byte     = 8'h00;
    assign w_rx_overflow = 1'b0;
`endif

    assign w_status = {5'b0, r_overflow, w_rx_avail, w_tx_full};

    always_comb begin
        w_io_rd_data = 8'h00;
        case (i_mem_a[2:0])
            3'd0:    w_io_rd_data = w_rx_avail ? w_rx_byte : 8'h00;
            3'd4:    w_io_rd_data = w_status;
            default: w_io_rd_data = 8'h00;
        endcase
    end

    // RAM port kept free of reset so it maps onto block RAM with a registered read.
    always_ff @(posedge i_clk) begin
        if (w_ram_wr)
            r_ram[w_ram_addr] <= i_mem_dout;
        if (w_ram_rd)
            r_ram_q <= r_ram[w_ram_addr];
    end

    always_ff @(posedge i_clk) begin
        if (w_push)
            r_fifo[r_wr_ptr] <= i_mem_dout;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_src_ram <= 1'b0;
            r_io_q    <= 8'h00;
        end else if (i_rdy && !i_mem_wr) begin
            r_src_ram <= !w_is_io;
            if (w_is_io)
                r_io_q <= w_io_rd_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr         <= '0;
            r_rd_ptr         <= '0;
            r_count          <= '0;
            r_io_buffer_full <= 1'b0;
            r_overflow       <= 1'b0;
            r_sim_done       <= 1'b0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count          <= w_count_next;
            // Two slots of headroom cover writes already in flight from the controller.
            r_io_buffer_full <= (w_count_next >= CW'(FIFO_DEPTH - 2));
            if ((w_push_req && !w_push) || w_rx_overflow)
                r_overflow <= 1'b1;
            if (w_io_sel4 && i_mem_wr)
                r_sim_done <= 1'b1;
        end
    end

    assign o_mem_din        = r_src_ram ? r_ram_q : r_io_q;
    assign o_io_buffer_full = r_io_buffer_full;
    assign o_sim_done       = r_sim_done;

endmodule

// File: tb/tb_ram_io_responder.sv
// Directed self-checking bench for ram_io_responder (RAM, TX FIFO, status, halt, optional RX).
module tb_ram_io_responder;
    logic        clk;
    logic        rst_n;
    logic        rdy;
    logic [31:0] mem_a;
    logic [7:0]  mem_dout;
    logic        mem_wr;
    logic [7:0]  mem_din;
    logic        io_buffer_full;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        sim_done;
`ifdef IO_RX_EN
    logic        rx_valid;
    logic [7:0]  rx_data;
`endif

    int checks = 0;
    int errors = 0;
    logic [7:0] expq[$];

    ram_io_responder #(.ADDR_WIDTH(17), .FIFO_DEPTH(8)) dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_rdy            (rdy),
        .i_mem_a          (mem_a),
        .i_mem_dout       (mem_dout),
        .i_mem_wr         (mem_wr),
        .o_mem_din        (mem_din),
        .o_io_buffer_full (io_buffer_full),
        .o_tx_valid       (tx_valid),
        .o_tx_data        (tx_data),
        .i_tx_ready       (tx_ready),
        .o_sim_done       (sim_done)
`ifdef IO_RX_EN
        ,
        .i_rx_valid       (rx_valid),
        .i_rx_data        (rx_data)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    // Present one access; returns at the following negedge, after the edge that consumed it.
    task automatic bus(input logic [31:0] a, input logic [7:0] d, input logic wr);
        mem_a    = a;
        mem_dout = d;
        mem_wr   = wr;
        @(negedge clk);
        $display("bus a=%05h wr=%0d d=%02h rdy=%0d -> din=%02h full=%0d txv=%0d txd=%02h done=%0d",
                 a, wr, d, rdy, mem_din, io_buffer_full, tx_valid, tx_data, sim_done);
    endtask

    initial begin
        rst_n    = 1'b0;
        rdy      = 1'b1;
        mem_a    = 32'h0;
        mem_dout = 8'h00;
        mem_wr   = 1'b0;
        tx_ready = 1'b0;
`ifdef IO_RX_EN
        rx_valid = 1'b0;
        rx_data  = 8'h00;
`endif
        repeat (2) @(negedge clk);
        check("rst_mem_din", mem_din, 8'h00);
        check("rst_full", {7'b0, io_buffer_full}, 8'h00);
        check("rst_tx_valid", {7'b0, tx_valid}, 8'h00);
        check("rst_tx_data", tx_data, 8'h00);
        check("rst_sim_done", {7'b0, sim_done}, 8'h00);
        rst_n = 1'b1;

        bus(32'h00010, 8'hA5, 1'b1);
        bus(32'h00010, 8'h00, 1'b0);
        check("ram_rd_a5", mem_din, 8'hA5);

        for (int i = 0; i < 4; i++) bus(32'h00100 + i, 8'(8'h11 * (i + 1)), 1'b1);
        for (int i = 0; i < 4; i++) begin
            bus(32'h00100 + i, 8'h00, 1'b0);
            check($sformatf("ram_seq%0d", i), mem_din, 8'(8'h11 * (i + 1)));
        end

        rdy = 1'b0;
        bus(32'h00010, 8'hFF, 1'b1);
        bus(32'h00100, 8'h00, 1'b0);
        check("rdy0_hold", mem_din, 8'h44);
        bus(32'h30000, 8'h99, 1'b1);
        check("rdy0_nopush", {7'b0, tx_valid}, 8'h00);
        rdy = 1'b1;
        bus(32'h00010, 8'h00, 1'b0);
        check("rdy0_nowrite", mem_din, 8'hA5);

        bus(32'h30001, 8'h00, 1'b0);
        check("io_other_rd", mem_din, 8'h00);
        bus(32'h20010, 8'h00, 1'b0);
        check("decode_ram_alias", mem_din, 8'hA5);
        bus(32'h30004, 8'h00, 1'b0);
        check("status_idle", mem_din, 8'h00);
        bus(32'h30000, 8'h00, 1'b0);
        check("rx_empty_rd", mem_din, 8'h00);

        for (int i = 0; i < 6; i++) begin
            bus(32'h30000, 8'(8'hB0 + i), 1'b1);
            expq.push_back(8'(8'hB0 + i));
            check($sformatf("push%0d_full", i), {7'b0, io_buffer_full}, {7'b0, (i >= 5)});
            check($sformatf("push%0d_valid", i), {7'b0, tx_valid}, 8'h01);
        end
        check("head_b0", tx_data, 8'hB0);
        for (int i = 6; i < 9; i++) begin
            bus(32'h30000, 8'(8'hB0 + i), 1'b1);
            if (i < 8) expq.push_back(8'(8'hB0 + i));
        end
        check("full_at_8", {7'b0, io_buffer_full}, 8'h01);
        bus(32'h30004, 8'h00, 1'b0);
        check("status_ovf_full", mem_din, 8'h05);

        tx_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            bus(32'h30000, 8'(8'hC0 + k), 1'b1);
            void'(expq.pop_front());
            expq.push_back(8'(8'hC0 + k));
            check($sformatf("simul%0d_head", k), tx_data, expq[0]);
            check($sformatf("simul%0d_full", k), {7'b0, io_buffer_full}, 8'h01);
        end
        for (int k = 0; k < 9; k++) begin
            bus(32'h00010, 8'h00, 1'b0);
            if (expq.size() != 0) void'(expq.pop_front());
            check($sformatf("drain%0d_valid", k), {7'b0, tx_valid}, {7'b0, (expq.size() != 0)});
            check($sformatf("drain%0d_head", k), tx_data, (expq.size() != 0) ? expq[0] : 8'h00);
            check($sformatf("drain%0d_full", k), {7'b0, io_buffer_full}, {7'b0, (expq.size() >= 6)});
        end
        tx_ready = 1'b0;
        bus(32'h30004, 8'h00, 1'b0);
        check("status_ovf_sticky", mem_din, 8'h04);

        check("sim_done_pre", {7'b0, sim_done}, 8'h00);
        bus(32'h30004, 8'h00, 1'b1);
        check("sim_done_set", {7'b0, sim_done}, 8'h01);
        bus(32'h00010, 8'h00, 1'b0);
        check("sim_done_sticky", {7'b0, sim_done}, 8'h01);
        check("pre_rst_din", mem_din, 8'hA5);

        bus(32'h30000, 8'hD0, 1'b1);
        bus(32'h30000, 8'hD1, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_mem_din", mem_din, 8'h00);
        check("arst_tx_valid", {7'b0, tx_valid}, 8'h00);
        check("arst_tx_data", tx_data, 8'h00);
        check("arst_full", {7'b0, io_buffer_full}, 8'h00);
        check("arst_sim_done", {7'b0, sim_done}, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        bus(32'h30004, 8'h00, 1'b0);
        check("post_rst_status", mem_din, 8'h00);
        check("post_rst_tx_valid", {7'b0, tx_valid}, 8'h00);

`ifdef IO_RX_EN
        rx_valid = 1'b1;
        rx_data  = 8'h5A;
        bus(32'h00010, 8'h00, 1'b0);
        rx_valid = 1'b0;
        bus(32'h30004, 8'h00, 1'b0);
        check("rx_status_avail", mem_din, 8'h02);
        bus(32'h30000, 8'h00, 1'b0);
        check("rx_pop_5a", mem_din, 8'h5A);
        bus(32'h30004, 8'h00, 1'b0);
        check("rx_status_clear", mem_din, 8'h00);
        rx_valid = 1'b1;
        rx_data  = 8'h11;
        bus(32'h00010, 8'h00, 1'b0);
        rx_data  = 8'h22;
        bus(32'h00010, 8'h00, 1'b0);
        rx_valid = 1'b0;
        bus(32'h30004, 8'h00, 1'b0);
        check("rx_status_ovf", mem_din, 8'h06);
        bus(32'h30000, 8'h00, 1'b0);
        check("rx_keep_first", mem_din, 8'h11);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ram_io_responder.md
# ram_io_responder

Memory-side responder for the CPU's byte-serial memory bus: it accepts one byte-wide access per cycle (`mem_a`/`mem_dout`/`mem_wr`) and returns read data on `mem_din` one cycle later. It contains a byte-addressed RAM and a small memory-mapped I/O window holding a TX byte FIFO, a status register and a halt flag. It drives `io_buffer_full` back to the CPU. It sits between the memory controller and the off-chip UART/testbench, completing the responder end of the controller's bus protocol.

## Interface
- `ADDR_WIDTH`, 17, RAM address bits; RAM size = 2^ADDR_WIDTH bytes.
- `FIFO_DEPTH`, 8, TX FIFO entries; power of two, ≥4.
- `clk`  in  1  single clock, posedge.
- `rst`  in  1  reset, asynchronous, active-low.
- `rdy`  in  1  global enable; when low, bus side is frozen.
- `mem_a`  in  32  byte address from controller.
- `mem_dout`  in  8  write data from controller.
- `mem_wr`  in  1  1 = write, 0 = read.
- `mem_din`  out  8  registered read data to controller.
- `io_buffer_full`  out  1  TX FIFO nearly full; controller must hold I/O writes.
- `tx_valid`  out  1  TX FIFO non-empty.
- `tx_data`  out  8  TX FIFO head byte.
- `tx_ready`  in  1  consumer accepts head byte when high with `tx_valid`.
- `sim_done`  out  1  sticky halt flag.
- `rx_valid`  in  1  (IO_RX_EN only) incoming byte strobe.
- `rx_data`  in  8  (IO_RX_EN only) incoming byte.

## Operation
- Decode: `mem_a[17:16] == 2'b11` → I/O window; otherwise RAM at `mem_a[ADDR_WIDTH-1:0]`.
- RAM write (`mem_wr=1`, `rdy=1`): byte stored at the clock edge. RAM read: byte registered into `mem_din` at the edge.
- I/O, keyed on `mem_a[2:0]`:
  - 0 write: push `mem_dout` into TX FIFO.
  - 0 read: pop RX holding register, or return 0x00 if empty.
  - 4 read: status `{5'b0, overflow, rx_avail, tx_full}`.
  - 4 write: set `sim_done`.
  - All other I/O reads return 0x00. Other I/O writes are ignored.
- A push to a full FIFO drops the byte and sets sticky `overflow`.
- `tx_valid = (count != 0)`; `tx_data` = head entry. Pop occurs when `tx_valid && tx_ready`. Draining is independent of `rdy`.
- Simultaneous push and pop: both occur, count unchanged; a push at `count == FIFO_DEPTH` with a simultaneous pop is accepted.
- Pointers are log2(FIFO_DEPTH) bits and wrap modulo depth. Count is log2(FIFO_DEPTH)+1 bits.
- `io_buffer_full` is registered and equals `(count_next >= FIFO_DEPTH-2)`, leaving 2 slots of headroom for writes already in flight.
- `rdy=0`: no RAM write, no push, no RX pop, `mem_din` holds its value.
- Reset (async, `rst=0`): `mem_din=0`, `io_buffer_full=0`, FIFO empty (`tx_valid=0`, `tx_data=0`), `overflow=0`, `sim_done=0`, RX holding register empty. RAM contents are not reset. Reset during an access aborts it; no partial state survives.

## Timing
- Read latency is 1 cycle: address presented in cycle N → `mem_din` valid throughout cycle N+1.
- Write in cycle N, read of same address in N+1 → new byte on `mem_din` in N+2.
- TX push at edge ending cycle N → `tx_valid=1` in N+1.
- `io_buffer_full` reflects the post-edge count in the same cycle the count changes.
- `sim_done` rises in the cycle after the write to 4.
- One access per cycle; no stall or handshake toward the controller apart from `io_buffer_full`.

## Configuration
- `IO_RX_EN` defined:
  - `rx_valid`/`rx_data` ports exist, feeding a 1-entry holding register.
  - `rx_avail` reflects occupancy of that register.
  - An `rx_valid` arriving while the register is full sets `overflow` and the new byte is dropped.
  - A read of address 0 clears `rx_avail`. An incoming byte and a pop in the same cycle: pop takes the old byte, the new byte is loaded.
- `IO_RX_EN` undefined: RX ports are absent, `rx_avail` is always 0, reads of 0 return 0x00.

## Test plan
- Write 0xA5 to 0x00010, then read 0x00010 → `mem_din=0xA5` one cycle after the read address.
- 4 consecutive byte writes 0x11,0x22,0x33,0x44 to 0x100..0x103, then 4 reads → `mem_din` sequence 0x11,0x22,0x33,0x44, each 1 cycle delayed.
- With `tx_ready=0`, push 6 bytes to 0x30000 (depth 8) → `io_buffer_full=1` after the 6th push. Push 3 more → count 8, `overflow=1`, status read = 0x05.
- `tx_ready=1` with simultaneous push every cycle → count constant, bytes emerge in order.
- Write to 0x30004 → `sim_done=1` next cycle. Assert `rst=0` mid-burst → all outputs 0 immediately.
- `IO_RX_EN`: `rx_valid` with 0x5A, read 0x30000 → 0x5A, then status `rx_avail=0`.
